// File: rtl/cachepool_pkg.sv
// Shared CachePool parameters and L1 maintenance types.
package cachepool_pkg;

  localparam int unsigned NumL1CacheCtrl      = 4;
  localparam int unsigned L1NumSet            = 256;
  localparam int unsigned L1AssoPerCtrl       = 4;
  localparam int unsigned MaintMaxOutstanding = 4;

  typedef enum logic [1:0] {
    MaintNone       = 2'b00,
    MaintFlush      = 2'b01,
    MaintInval      = 2'b10,
    MaintFlushInval = 2'b11
  } maint_op_e;

  typedef enum logic [1:0] {
    MaintIdle,
    MaintIssue,
    MaintDrain,
    MaintDone
  } maint_state_e;

endpackage

// File: rtl/cachepool_maint_tracker.sv
// Per-controller maintenance tracking: accepted bit, outstanding count,
// issue limit and detection of responses with nothing outstanding.
module cachepool_maint_tracker
  import cachepool_pkg::*;
#(
  parameter int unsigned MaxOutstanding = MaintMaxOutstanding
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic mask_i,
  input  logic issue_next_i,
  input  logic ready_i,
  input  logic rsp_valid_i,
  output logic valid_o,
  output logic accepted_o,
  output logic idle_o,
  output logic proto_err_c_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            hs;
  logic            accepted_d;
  logic [CntW-1:0] outst_q;
  logic [CntW-1:0] outst_d;

  // Next accepted bit and outstanding count; flag responses with nothing pending
  always_comb begin
    hs            = valid_o & ready_i;
    accepted_d    = clear_i ? 1'b0 : (accepted_o | hs);
    outst_d       = outst_q;
    proto_err_c_o = 1'b0;
    if (hs && !rsp_valid_i) begin
      outst_d = outst_q + CntW'(1);
    end else if (!hs && rsp_valid_i) begin
      if (outst_q == '0) proto_err_c_o = 1'b1;
      else               outst_d       = outst_q - CntW'(1);
    end
  end

  // Valid is registered from next-state so it never drops before its handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accepted_o <= 1'b0;
      outst_q    <= '0;
      idle_o     <= 1'b1;
      valid_o    <= 1'b0;
    end else begin
      accepted_o <= accepted_d;
      outst_q    <= outst_d;
      idle_o     <= (outst_d == '0);
      valid_o    <= issue_next_i & mask_i & ~accepted_d &
                    (outst_d < CntW'(MaxOutstanding));
    end
  end

endmodule

// File: rtl/cachepool_l1_maint_seq.sv
// Walks every set x way of the selected L1 controllers, broadcasting one
// maintenance request per index and reporting completion with sticky error.
module cachepool_l1_maint_seq
  import cachepool_pkg::*;
#(
  parameter int unsigned NumCtrl        = NumL1CacheCtrl,
  parameter int unsigned NumSet         = L1NumSet,
  parameter int unsigned NumWay         = L1AssoPerCtrl,
  parameter int unsigned MaxOutstanding = MaintMaxOutstanding,
  localparam int unsigned SetW          = $clog2(NumSet),
  localparam int unsigned WayW          = $clog2(NumWay)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [NumCtrl-1:0] cmd_mask_i,
  output logic               done_valid_o,
  input  logic               done_ready_i,
  output logic               done_err_o,
  output logic               busy_o,
  output logic [NumCtrl-1:0] maint_valid_o,
  input  logic [NumCtrl-1:0] maint_ready_i,
  output logic [1:0]         maint_op_o,
  output logic [SetW-1:0]    maint_set_o,
  output logic [WayW-1:0]    maint_way_o,
  input  logic [NumCtrl-1:0] maint_rsp_valid_i,
  input  logic [NumCtrl-1:0] maint_rsp_err_i
);

  localparam int unsigned IdxW = SetW + WayW;

  maint_state_e       state_q, state_d;
  maint_op_e          op_q, op_d;
  logic [NumCtrl-1:0] mask_q, mask_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               err_q, err_d;
  logic               clear_acc;
  logic               issue_next;
  logic               all_acc;
  logic               rsp_err;
  logic [NumCtrl-1:0] hs;
  logic [NumCtrl-1:0] valid;
  logic [NumCtrl-1:0] accepted;
  logic [NumCtrl-1:0] idle;
  logic [NumCtrl-1:0] proto_err;

  // Index is {set, way}, so a plain increment walks ways inside sets
  assign maint_valid_o = valid;
  assign maint_op_o    = op_q;
  assign maint_set_o   = idx_q[IdxW-1 -: SetW];
  assign maint_way_o   = idx_q[WayW-1:0];
  assign done_err_o    = err_q;

  // Per-controller request tracking
  for (genvar c = 0; c < NumCtrl; c++) begin : g_trk
    cachepool_maint_tracker #(
      .MaxOutstanding(MaxOutstanding)
    ) u_trk (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_acc),
      .mask_i       (mask_d[c]),
      .issue_next_i (issue_next),
      .ready_i      (maint_ready_i[c]),
      .rsp_valid_i  (maint_rsp_valid_i[c]),
      .valid_o      (valid[c]),
      .accepted_o   (accepted[c]),
      .idle_o       (idle[c]),
      .proto_err_c_o(proto_err[c])
    );
  end

  // Sequencer next state: command latch, index walk, drain and error tracking
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    err_d     = err_q;
    clear_acc = 1'b0;
    hs        = valid & maint_ready_i;
    all_acc   = &(~mask_q | accepted | hs);
    rsp_err   = |(maint_rsp_valid_i & maint_rsp_err_i) | (|proto_err);
    unique case (state_q)
      MaintIdle: begin
        if (cmd_valid_i) begin
          op_d      = maint_op_e'(cmd_op_i);
          mask_d    = cmd_mask_i;
          idx_d     = '0;
          err_d     = 1'b0;
          clear_acc = 1'b1;
          if (maint_op_e'(cmd_op_i) == MaintNone) begin
            err_d   = 1'b1;
            state_d = MaintDone;
          end else if (cmd_mask_i == '0) begin
            state_d = MaintDone;
          end else begin
            state_d = MaintIssue;
          end
        end
      end
      MaintIssue: begin
        err_d = err_q | rsp_err;
        if (all_acc) begin
          clear_acc = 1'b1;
          if (idx_q == '1) state_d = MaintDrain;
          else             idx_d   = idx_q + IdxW'(1);
        end
      end
      MaintDrain: begin
        err_d = err_q | rsp_err;
        if (&idle) state_d = MaintDone;
      end
      MaintDone: begin
        if (done_ready_i) state_d = MaintIdle;
      end
      default: state_d = MaintIdle;
    endcase
    issue_next = (state_d == MaintIssue);
  end

  // State and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= MaintIdle;
      op_q         <= MaintNone;
      mask_q       <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      cmd_ready_o  <= (state_d == MaintIdle);
      busy_o       <= (state_d != MaintIdle);
      done_valid_o <= (state_d == MaintDone);
    end
  end

endmodule
